cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
Shares one CORDIC core (AXI-Stream, 32-bit cartesian input, 16-bit result) between NUM_REQ requester streams. Round-robin arbitration grants whole tlast-delimited packets to the core's input. An in-order ID FIFO records which requester owns each accepted beat. Each result beat is routed back to its owner's response stream. Sits between the compute clients and the CORDIC wrapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_W, 32, CORDIC input data width.
- OUT_W, 16, CORDIC result data width.
- ID_DEPTH, 32, ID FIFO depth (power of two); bounds in-flight beats.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- req_tdata  in  NUM_REQ*IN_W  requester data; requester i is at slice i.
- req_tvalid  in  NUM_REQ  requester valid.
- req_tlast  in  NUM_REQ  requester end of packet.
- req_tready  out  NUM_REQ  requester ready.
- cor_tdata  out  IN_W  to CORDIC s_axis_cartesian_tdata.
- cor_tvalid  out  1  to CORDIC input valid.
- cor_tlast  out  1  to CORDIC input tlast.
- cor_tready  in  1  from CORDIC input ready.
- cor_dout_tdata  in  OUT_W  CORDIC result data.
- cor_dout_tvalid  in  1  CORDIC result valid.
- cor_dout_tlast  in  1  CORDIC result tlast.
- cor_dout_tready  out  1  CORDIC result ready.
- rsp_tdata  out  NUM_REQ*OUT_W  per-requester result data.
- rsp_tvalid  out  NUM_REQ  per-requester result valid.
- rsp_tlast  out  NUM_REQ  per-requester result tlast.
- rsp_tready  in  NUM_REQ  per-requester result ready.
- inflight  out  $clog2(ID_DEPTH)+1  ID FIFO occupancy.
- err_no_id  out  1  sticky error flag: result arrived with no owner recorded.

Behaviour:
- Reset (async, reset_n=0):
  - FSM=IDLE, FIFO empty, inflight=0, err_no_id=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
  - All req_tready, cor_tvalid, rsp_tvalid and cor_dout_tready read 0 while in reset.
  - Reset mid-packet drops the packet; no partial state survives.
- FSM IDLE:
  - cor_tvalid=0 and all req_tready=0.
  - If any req_tvalid is high, pick the first valid index strictly after the pointer (wrapping); register it as gnt; go to LOCK.
  - Grant latency is 1 cycle from tvalid to the first forwarding cycle.
- FSM LOCK (combinational forwarding from requester gnt):
  - cor_tdata=req_tdata[gnt], cor_tlast=req_tlast[gnt].
  - cor_tvalid=req_tvalid[gnt] & ~full.
  - req_tready[gnt]=cor_tready & ~full; every other req_tready=0.
  - An accepted beat (cor_tvalid & cor_tready) pushes gnt into the ID FIFO.
  - Accepting a beat with tlast=1 sets pointer=gnt and returns to IDLE.
  - Packets are never split or interleaved on the CORDIC input.
- ID FIFO full: pushing is blocked, even if a pop happens in the same cycle (no full bypass). Simultaneous push and pop when not full leaves inflight unchanged.
- Response path (head = FIFO head ID, defined only when the FIFO is not empty):
  - rsp_tdata for every requester carries cor_dout_tdata; rsp_tlast for every requester carries cor_dout_tlast.
  - rsp_tvalid[head]=cor_dout_tvalid & ~empty; all other rsp_tvalid=0.
  - cor_dout_tready=rsp_tready[head] & ~empty.
  - A result handshake pops the FIFO.
  - A stalled owner blocks all later results (strict in-order delivery).
- FIFO empty while cor_dout_tvalid=1: cor_dout_tready stays 0 and err_no_id sets to 1. err_no_id clears only on reset.
- Requester tvalid dropping mid-packet: the arbiter stays in LOCK and waits; grant is never revoked before tlast.

Optional Feature:
- Macro CORDIC_ARB_PERF_EN.
- When defined:
  - Adds output port perf_pkts, NUM_REQ*16 bits.
  - Slice i is a 16-bit counter of input packets granted to requester i. It increments on each accepted tlast beat, saturates at 16'hFFFF, and resets to 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single packet routing: req1 sends 3 beats 0x00010002, 0x00030004, 0x00050006 (tlast on beat 3), cor_tready=1 → first cor_tvalid one cycle after req_tvalid; beats appear in order; inflight reaches 3. Model returns 0x1111, 0x2222, 0x3333 → only rsp_tvalid[1] asserts, data unchanged, inflight returns to 0.
- Round robin: all 4 requesters hold 1-beat packets continuously → grant order 0,1,2,3,0,1; no requester is granted twice in a row while others are valid.
- FIFO full with ID_DEPTH=4: rsp_tready=0 and req0 offers 6 beats → exactly 4 accepted, req_tready[0]=0 and inflight=4. Set rsp_tready[0]=1 → remaining beats drain, one accepted per pop.
- Ordered return: req2 sends 2 beats, then req0 sends 1 beat; rsp_tready[2]=0 for 5 cycles → cor_dout_tready=0 and rsp_tvalid[0]=0 during the stall; delivery order afterwards is 2,2,0.
- Reset mid-packet: reset_n=0 after beat 1 of 3 from req3 → all valid/ready outputs 0 immediately, inflight=0. After release, with req0 and req3 both valid, req0 is granted first.
- Spurious result: FIFO empty and cor_dout_tvalid=1 → cor_dout_tready=0 and err_no_id=1, which stays set until reset. With CORDIC_ARB_PERF_EN defined, perf_pkts slice 0 saturates at 0xFFFF after 65536+ granted packets.

Source files
------------

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - packet round-robin arbiter sharing one CORDIC core, in-order result routing
// Optional per-requester packet counters on perf_pkts when CORDIC_ARB_PERF_EN is defined.
module cordic_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int ID_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ*IN_W-1:0]        req_tdata,
    input  logic [NUM_REQ-1:0]             req_tvalid,
    input  logic [NUM_REQ-1:0]             req_tlast,
    output logic [NUM_REQ-1:0]             req_tready,
    output logic [IN_W-1:0]                cor_tdata,
    output logic                           cor_tvalid,
    output logic                           cor_tlast,
    input  logic                           cor_tready,
    input  logic [OUT_W-1:0]               cor_dout_tdata,
    input  logic                           cor_dout_tvalid,
    input  logic                           cor_dout_tlast,
    output logic                           cor_dout_tready,
    output logic [NUM_REQ*OUT_W-1:0]       rsp_tdata,
    output logic [NUM_REQ-1:0]             rsp_tvalid,
    output logic [NUM_REQ-1:0]             rsp_tlast,
    input  logic [NUM_REQ-1:0]             rsp_tready,
    output logic [$clog2(ID_DEPTH):0]      inflight,
    output logic                           err_no_id
`ifdef CORDIC_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]          perf_pkts
`endif
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW  = $clog2(ID_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] cand;
    logic           any_valid;

    logic [IDW-1:0] id_mem [ID_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [IDW-1:0] head;

    // Scan from farthest to nearest so the nearest valid index after ptr wins.
    always_comb begin
        pick      = ptr;
        cand      = ptr;
        any_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (req_tvalid[cand]) begin
                pick      = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign full  = (count == CW'(ID_DEPTH));
    assign empty = (count == '0);
    assign head  = id_mem[rd_ptr];
    assign push  = cor_tvalid & cor_tready;
    assign pop   = cor_dout_tvalid & cor_dout_tready;

    always_comb begin
        cor_tdata  = req_tdata[gnt*IN_W +: IN_W];
        cor_tlast  = req_tlast[gnt];
        cor_tvalid = (state == LOCK) & req_tvalid[gnt] & ~full;
        req_tready = '0;
        if (state == LOCK) begin
            req_tready[gnt] = cor_tready & ~full;
        end
    end

    always_comb begin
        rsp_tvalid = '0;
        if (!empty) begin
            rsp_tvalid[head] = cor_dout_tvalid;
        end
        cor_dout_tready = ~empty & rsp_tready[head];
    end

    assign rsp_tdata = {NUM_REQ{cor_dout_tdata}};
    assign rsp_tlast = {NUM_REQ{cor_dout_tlast}};
    assign inflight  = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= IDW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt   <= pick;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (push && cor_tlast) begin
                        ptr   <= gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Full blocks push through cor_tvalid, so a same-cycle pop never frees a slot early.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_no_id <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (cor_dout_tvalid && empty) err_no_id <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= gnt;
    end

`ifdef CORDIC_ARB_PERF_EN
    logic [15:0] perf_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) perf_cnt[i] <= '0;
        end else if (push && cor_tlast && perf_cnt[gnt] != 16'hFFFF) begin
            perf_cnt[gnt] <= perf_cnt[gnt] + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        assign perf_pkts[i*16 +: 16] = perf_cnt[i];
    end
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - scoreboard bench for cordic_arbiter with a CORDIC stand-in model
// Perf counter checks compile in when CORDIC_ARB_PERF_EN is defined.
module tb_cordic_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int IN_W     = 32;
    localparam int OUT_W    = 16;
    localparam int ID_DEPTH = 4;
    localparam int CW       = $clog2(ID_DEPTH) + 1;
    localparam int NPKT     = 6;

    typedef struct packed { logic last; logic [IN_W-1:0] data; } rbeat_t;
    typedef struct packed { logic [2:0] id; logic last; logic [IN_W-1:0] data; } ebeat_t;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_REQ*IN_W-1:0]  req_tdata;
    logic [NUM_REQ-1:0]       req_tvalid;
    logic [NUM_REQ-1:0]       req_tlast;
    logic [NUM_REQ-1:0]       req_tready;
    logic [IN_W-1:0]          cor_tdata;
    logic                     cor_tvalid;
    logic                     cor_tlast;
    logic                     cor_tready;
    logic [OUT_W-1:0]         cor_dout_tdata;
    logic                     cor_dout_tvalid;
    logic                     cor_dout_tlast;
    logic                     cor_dout_tready;
    logic [NUM_REQ*OUT_W-1:0] rsp_tdata;
    logic [NUM_REQ-1:0]       rsp_tvalid;
    logic [NUM_REQ-1:0]       rsp_tlast;
    logic [NUM_REQ-1:0]       rsp_tready;
    logic [CW-1:0]            inflight;
    logic                     err_no_id;
`ifdef CORDIC_ARB_PERF_EN
    logic [NUM_REQ*16-1:0]    perf_pkts;
`endif

    rbeat_t         req_q [NUM_REQ][$];
    ebeat_t         exp_cor[$];
    ebeat_t         exp_rsp[$];
    logic [OUT_W:0] core_q[$];
    int             gap_pct      = 0;
    int             core_rdy_pct = 100;
    int             core_out_pct = 100;
    int             rsp_pct [NUM_REQ];
    bit             spur         = 0;
    int             n_vec        = 0;
    int             n_err        = 0;

    cordic_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .ID_DEPTH(ID_DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_tdata      (req_tdata),
        .req_tvalid     (req_tvalid),
        .req_tlast      (req_tlast),
        .req_tready     (req_tready),
        .cor_tdata      (cor_tdata),
        .cor_tvalid     (cor_tvalid),
        .cor_tlast      (cor_tlast),
        .cor_tready     (cor_tready),
        .cor_dout_tdata (cor_dout_tdata),
        .cor_dout_tvalid(cor_dout_tvalid),
        .cor_dout_tlast (cor_dout_tlast),
        .cor_dout_tready(cor_dout_tready),
        .rsp_tdata      (rsp_tdata),
        .rsp_tvalid     (rsp_tvalid),
        .rsp_tlast      (rsp_tlast),
        .rsp_tready     (rsp_tready),
        .inflight       (inflight),
        .err_no_id      (err_no_id)
`ifdef CORDIC_ARB_PERF_EN
        ,
        .perf_pkts      (perf_pkts)
`endif
    );

    function automatic logic [OUT_W-1:0] core_fn(input logic [IN_W-1:0] d);
        return d[31:16] + (d[15:0] ^ 16'hA5C3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input int r, input rbeat_t b);
        ebeat_t e;
        e.id   = 3'(r);
        e.last = b.last;
        e.data = b.data;
        exp_cor.push_back(e);
        e.data = {16'h0, core_fn(b.data)};
        exp_rsp.push_back(e);
    endtask

    task automatic add_beat(input int r, input logic [IN_W-1:0] d, input logic l);
        rbeat_t b;
        b.data = d;
        b.last = l;
        req_q[r].push_back(b);
        expect_beat(r, b);
    endtask

    task automatic wait_req(input int r);
        int n = 0;
        while (req_q[r].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_req_budget", 32'(n < 200), 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || inflight != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_budget"}, 32'(n < 5000), 1);
        check({name, "_inflight"}, inflight, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        repeat (2) @(negedge clk);
        exp_cor.delete();
        exp_rsp.delete();
        reset_n = 1;
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Requester streams: hold each beat until handshake, optional gaps only inside a packet.
    initial begin : req_drv
        logic [NUM_REQ-1:0] hs;
        int                 gap [NUM_REQ];
        rbeat_t             b;
        req_tvalid = '0;
        req_tdata  = '0;
        req_tlast  = '0;
        foreach (gap[i]) gap[i] = 0;
        forever begin
            @(negedge clk);
            hs = req_tvalid & req_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!reset_n) begin
                    req_q[i].delete();
                    gap[i] = 0;
                end else if (hs[i]) begin
                    b = req_q[i].pop_front();
                    if (!b.last && $urandom_range(99) < gap_pct) gap[i] = $urandom_range(3, 1);
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
                if (req_q[i].size() > 0 && gap[i] == 0) begin
                    req_tvalid[i]              = 1'b1;
                    req_tdata[i*IN_W +: IN_W] = req_q[i][0].data;
                    req_tlast[i]               = req_q[i][0].last;
                end else begin
                    req_tvalid[i] = 1'b0;
                    req_tlast[i]  = 1'b0;
                end
            end
        end
    end

    initial begin : core_model
        logic            c_in;
        logic            c_out;
        logic            dl;
        logic            spur_drv;
        logic [IN_W-1:0] dd;
        cor_tready      = 0;
        cor_dout_tvalid = 0;
        cor_dout_tdata  = '0;
        cor_dout_tlast  = 0;
        spur_drv        = 0;
        forever begin
            @(negedge clk);
            c_in  = cor_tvalid & cor_tready;
            c_out = cor_dout_tvalid & cor_dout_tready;
            dd    = cor_tdata;
            dl    = cor_tlast;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                core_q.delete();
                cor_dout_tvalid = 0;
                cor_tready      = 0;
                spur_drv        = 0;
            end else begin
                if (c_in) core_q.push_back({dl, core_fn(dd)});
                if (spur) begin
                    cor_dout_tvalid = 1;
                    cor_dout_tdata  = 16'hDEAD;
                    cor_dout_tlast  = 0;
                    spur_drv        = 1;
                end else begin
                    if (spur_drv) begin
                        cor_dout_tvalid = 0;
                        spur_drv        = 0;
                    end
                    if (c_out || !cor_dout_tvalid) begin
                        if (core_q.size() > 0 && $urandom_range(99) < core_out_pct) begin
                            {cor_dout_tlast, cor_dout_tdata} = core_q.pop_front();
                            cor_dout_tvalid = 1;
                        end else begin
                            cor_dout_tvalid = 0;
                        end
                    end
                end
                cor_tready = ($urandom_range(99) < core_rdy_pct);
            end
        end
    end

    initial begin : rsp_drv
        rsp_tready = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_tready[i] = reset_n && ($urandom_range(99) < rsp_pct[i]);
            end
        end
    end

    initial begin : monitor
        ebeat_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (cor_tvalid && cor_tready) begin
                    check("cor_beat_expected", 32'(exp_cor.size() > 0), 1);
                    if (exp_cor.size() > 0) begin
                        e = exp_cor.pop_front();
                        check("cor_tdata", cor_tdata, e.data);
                        check("cor_tlast", 32'(cor_tlast), 32'(e.last));
                    end
                end
                if ($countones(rsp_tvalid) > 1) check("rsp_onehot", $countones(rsp_tvalid), 1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (rsp_tvalid[i] && rsp_tready[i]) begin
                        check("rsp_beat_expected", 32'(exp_rsp.size() > 0), 1);
                        if (exp_rsp.size() > 0) begin
                            e = exp_rsp.pop_front();
                            check("rsp_owner", i, 32'(e.id));
                            check("rsp_tdata", rsp_tdata[i*OUT_W +: OUT_W], e.data[OUT_W-1:0]);
                            check("rsp_tlast", 32'(rsp_tlast[i]), 32'(e.last));
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        rbeat_t gen [NUM_REQ][$];
        rbeat_t rb;
        int     n;
        int     ptr;
        int     idx;
        int     len;
        bit     found;

        foreach (rsp_pct[i]) rsp_pct[i] = 100;
        reset_n = 0;
        repeat (3) @(negedge clk);
        check("rst_req_tready", req_tready, 0);
        check("rst_cor_tvalid", cor_tvalid, 0);
        check("rst_rsp_tvalid", rsp_tvalid, 0);
        check("rst_cor_dout_tready", cor_dout_tready, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err_no_id", err_no_id, 0);
        reset_n = 1;
        repeat (2) @(negedge clk);

        // Single packet from requester 1, results held until released.
        rsp_pct[1] = 0;
        add_beat(1, 32'h00010002, 1'b0);
        add_beat(1, 32'h00030004, 1'b0);
        add_beat(1, 32'h00050006, 1'b1);
        n = 0;
        while (!req_tvalid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_cor_tvalid_idle", cor_tvalid, 0);
        @(negedge clk);
        check("t1_cor_tvalid_lock", cor_tvalid, 1);
        wait_req(1);
        repeat (3) @(negedge clk);
        check("t1_inflight", inflight, 3);
        check("t1_rsp_tvalid", rsp_tvalid, 4'b0010);
        rsp_pct[1] = 100;
        drain("t1_drain");

        // FIFO full with results stalled.
        foreach (rsp_pct[i]) rsp_pct[i] = 0;
        for (int b = 0; b < 6; b++) add_beat(0, $urandom, b == 5);
        repeat (15) @(negedge clk);
        check("t2_inflight_full", inflight, ID_DEPTH);
        check("t2_req_tready0", req_tready[0], 0);
        check("t2_accepted", 6 - req_q[0].size(), ID_DEPTH);
        rsp_pct[0] = 100;
        drain("t2_drain");

        // Stalled owner blocks later results.
        foreach (rsp_pct[i]) rsp_pct[i] = 100;
        rsp_pct[2] = 0;
        add_beat(2, $urandom, 1'b0);
        add_beat(2, $urandom, 1'b1);
        wait_req(2);
        add_beat(0, $urandom, 1'b1);
        wait_req(0);
        repeat (2) @(negedge clk);
        check("t3_rsp_tvalid2", rsp_tvalid[2], 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_cor_dout_tready", cor_dout_tready, 0);
            check("t3_rsp_tvalid0", rsp_tvalid[0], 0);
        end
        rsp_pct[2] = 100;
        drain("t3_drain");

        // Reset in the middle of a packet from requester 3.
        foreach (rsp_pct[i]) rsp_pct[i] = 0;
        add_beat(3, 32'hC0DE0001, 1'b0);
        add_beat(3, 32'hC0DE0002, 1'b0);
        add_beat(3, 32'hC0DE0003, 1'b1);
        n = 0;
        while (req_q[3].size() > 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        reset_n = 0;
        #1;
        check("t4_req_tready", req_tready, 0);
        check("t4_cor_tvalid", cor_tvalid, 0);
        check("t4_rsp_tvalid", rsp_tvalid, 0);
        check("t4_cor_dout_tready", cor_dout_tready, 0);
        check("t4_inflight", inflight, 0);
        repeat (2) @(negedge clk);
        exp_cor.delete();
        exp_rsp.delete();
        reset_n = 1;
        foreach (rsp_pct[i]) rsp_pct[i] = 100;
        add_beat(0, $urandom, 1'b1);
        add_beat(3, $urandom, 1'b1);
        drain("t4_drain");

        // Result with no owner recorded.
        spur = 1;
        @(negedge clk);
        check("t5_cor_dout_tready", cor_dout_tready, 0);
        @(negedge clk);
        check("t5_err_set", err_no_id, 1);
        spur = 0;
        repeat (5) @(negedge clk);
        check("t5_err_sticky", err_no_id, 1);
        do_reset();
        check("t5_err_cleared", err_no_id, 0);

        // Random traffic from every requester; order model is plain packet round robin.
        gap_pct      = 30;
        core_rdy_pct = 70;
        core_out_pct = 60;
        foreach (rsp_pct[i]) rsp_pct[i] = $urandom_range(100, 40);
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int p = 0; p < NPKT; p++) begin
                len = $urandom_range(4, 1);
                for (int b = 0; b < len; b++) begin
                    rb.data = $urandom;
                    rb.last = (b == len - 1);
                    gen[r].push_back(rb);
                    req_q[r].push_back(rb);
                end
            end
        end
        ptr = NUM_REQ - 1;
        do begin
            found = 0;
            for (int k = 1; k <= NUM_REQ && !found; k++) begin
                idx = (ptr + k) % NUM_REQ;
                if (gen[idx].size() > 0) begin
                    found = 1;
                    ptr   = idx;
                    do begin
                        rb = gen[idx].pop_front();
                        expect_beat(idx, rb);
                    end while (!rb.last);
                end
            end
        end while (found);
        drain("t6_drain");
        check("t6_cor_left", exp_cor.size(), 0);
        check("t6_err_no_id", err_no_id, 0);
`ifdef CORDIC_ARB_PERF_EN
        for (int r = 0; r < NUM_REQ; r++) check("t6_perf_pkts", perf_pkts[r*16 +: 16], NPKT);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
